// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states
// and the access legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    LD_CAP = 3'd2,
    MERGE  = 3'd3,
    WR     = 3'd4,
    RESP   = 3'd5
  } lsu_state_t;

  // Unsigned sizes exist only for loads; halfwords and words must be naturally aligned.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3,
                                    input logic [1:0] offset);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !we;
      F3_H:    ok = !offset[0];
      F3_HU:   ok = !we && !offset[0];
      F3_W:    ok = (offset == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: load extraction with sign or
// zero extension, and the read-modify-write merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word[{offset, 3'b000} +: 8];
    half_sel = rd_word[{offset[1], 4'b0000} +: 16];
    load_data = rd_word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // Untouched lanes keep the RAM contents; a full word simply takes the store data.
  always_comb begin
    merge_data = rd_word;
    case (funct3)
      F3_B:    merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
      F3_H:    merge_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns RISC-V byte/half/word accesses into word accesses on
// a RAM without byte enables, using read-modify-write for SB/SH.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_wr_data,
  output logic              ram_wrEn,
  output logic              ram_rdEn,
  input  logic [DWIDTH-1:0] ram_rd_data
);

  lsu_state_t        state, next_state;
  logic              lat_we;
  logic [2:0]        lat_funct3;
  logic [1:0]        lat_offset;
  logic [DWIDTH-1:0] lat_wdata;
  logic              lat_err;
  logic              accept;
  logic              req_legal;
  logic [DWIDTH-1:0] load_data;
  logic [DWIDTH-1:0] merge_data;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_legal = is_legal(req_we, req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .funct3     (lat_funct3),
    .offset     (lat_offset),
    .rd_word    (ram_rd_data),
    .wdata      (lat_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!req_legal)
            next_state = RESP;
          else if (req_we && req_funct3 == F3_W)
            next_state = WR;
          else
            next_state = RD;
        end
      end
      RD:      next_state = lat_we ? MERGE : LD_CAP;
      LD_CAP:  next_state = RESP;
      MERGE:   next_state = WR;
      WR:      next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with RD/WR
  // while still coming straight out of flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_we      <= 1'b0;
      lat_funct3  <= 3'b000;
      lat_offset  <= 2'b00;
      lat_wdata   <= '0;
      lat_err     <= 1'b0;
      ram_rdEn    <= 1'b0;
      ram_wrEn    <= 1'b0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
    end else begin
      state      <= next_state;
      ram_rdEn   <= (next_state == RD);
      ram_wrEn   <= (next_state == WR);
      resp_valid <= (state == RESP);
      resp_err   <= (state == RESP) && lat_err;

      if (accept) begin
        lat_we     <= req_we;
        lat_funct3 <= req_funct3;
        lat_offset <= req_addr[1:0];
        lat_wdata  <= req_wdata;
        lat_err    <= !req_legal;
        ram_addr   <= {req_addr[AWIDTH-1:2], 2'b00};
        if (req_legal && req_we && req_funct3 == F3_W)
          ram_wr_data <= req_wdata;
      end

      if (state == LD_CAP)
        resp_rdata <= load_data;
      if (state == MERGE)
        ram_wr_data <= merge_data;
      if (state == RESP && lat_err)
        resp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word RAM model with one-cycle read
// latency, per-request timing/strobe checks and a mid-RMW reset case.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] ram_addr;
  logic [31:0] ram_wr_data;
  logic        ram_wrEn;
  logic        ram_rdEn;
  logic [31:0] ram_rd_data;

  logic [31:0] mem [0:63];
  logic        init_en;
  logic [5:0]  init_idx;
  logic [31:0] init_val;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          resp_cyc;
    int          rd_cyc;
    int          wr_cyc;
    logic [31:0] wdata;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  load_store_unit #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_rdata  (resp_rdata),
    .ram_addr    (ram_addr),
    .ram_wr_data (ram_wr_data),
    .ram_wrEn    (ram_wrEn),
    .ram_rdEn    (ram_rdEn),
    .ram_rd_data (ram_rd_data)
  );

  // Word RAM: registered read, data appears the cycle after ram_rdEn.
  always @(posedge clk) begin
    if (init_en)
      mem[init_idx] <= init_val;
    else if (ram_wrEn)
      mem[ram_addr[7:2]] <= ram_wr_data;
    if (ram_rdEn)
      ram_rd_data <= mem[ram_addr[7:2]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, wanted %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input logic err, input int resp_cyc, input int rd_cyc,
                               input int wr_cyc, input logic [31:0] wr_data);
    exp_t        e;
    int          rd_cnt, wr_cnt, both, first_rd, first_wr, n, resp_at;
    logic [31:0] seen_wdata, seen_addr;
    e = '{rdata, err, resp_cyc, rd_cyc, wr_cyc, wr_data, {addr[31:2], 2'b00}};
    exp_q.push_back(e);
    rd_cnt = 0; wr_cnt = 0; both = 0; first_rd = 0; first_wr = 0; resp_at = 0;
    seen_wdata = '0; seen_addr = '0;

    @(negedge clk);
    checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h5A5A_5A5A;

    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ram_rdEn) begin
        rd_cnt++;
        if (first_rd == 0) first_rd = n;
        seen_addr = ram_addr;
      end
      if (ram_wrEn) begin
        wr_cnt++;
        if (first_wr == 0) first_wr = n;
        seen_wdata = ram_wr_data;
        seen_addr  = ram_addr;
      end
      if (ram_rdEn && ram_wrEn) both++;
      if (resp_valid) begin
        resp_at = n;
        break;
      end
    end

    e = exp_q.pop_front();
    if (resp_at == 0) begin
      checkOutput("resp_timeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("resp_cycle", resp_at, e.resp_cyc);
    checkOutput("resp_rdata", resp_rdata, e.rdata);
    checkOutput("resp_err", {31'd0, resp_err}, {31'd0, e.err});
    checkOutput("rdEn_count", rd_cnt, (e.rd_cyc != 0) ? 1 : 0);
    checkOutput("rdEn_cycle", first_rd, e.rd_cyc);
    checkOutput("wrEn_count", wr_cnt, (e.wr_cyc != 0) ? 1 : 0);
    checkOutput("wrEn_cycle", first_wr, e.wr_cyc);
    checkOutput("rd_wr_overlap", both, 0);
    if (e.wr_cyc != 0)
      checkOutput("ram_wr_data", seen_wdata, e.wdata);
    if (rd_cnt + wr_cnt > 0)
      checkOutput("ram_addr", seen_addr, e.addr);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rdEn"}, {31'd0, ram_rdEn}, 32'd0);
    checkOutput({tag, "_wrEn"}, {31'd0, ram_wrEn}, 32'd0);
    checkOutput({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    checkOutput({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    checkOutput({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    checkOutput({tag, "_ram_addr"}, ram_addr, 32'd0);
    checkOutput({tag, "_ram_wr_data"}, ram_wr_data, 32'd0);
  endtask

  initial begin
    int wr_seen;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    init_en    = 1'b1;
    init_idx   = 6'd4;
    init_val   = 32'h8765_4321;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    init_en = 1'b0;
    rst_n   = 1'b1;

    // Loads from the preloaded word at 0x10
    applyStimulus(1'b0, F3_B,  32'h13, 32'h0, 32'hFFFF_FF87, 1'b0, 4, 1, 0, 32'h0);
    applyStimulus(1'b0, F3_BU, 32'h13, 32'h0, 32'h0000_0087, 1'b0, 4, 1, 0, 32'h0);
    applyStimulus(1'b0, F3_HU, 32'h12, 32'h0, 32'h0000_8765, 1'b0, 4, 1, 0, 32'h0);
    applyStimulus(1'b0, F3_H,  32'h12, 32'h0, 32'hFFFF_8765, 1'b0, 4, 1, 0, 32'h0);
    applyStimulus(1'b0, F3_H,  32'h10, 32'h0, 32'h0000_4321, 1'b0, 4, 1, 0, 32'h0);
    applyStimulus(1'b0, F3_W,  32'h10, 32'h0, 32'h8765_4321, 1'b0, 4, 1, 0, 32'h0);

    // Stores; resp_rdata keeps the last load value
    applyStimulus(1'b1, F3_B,  32'h11, 32'h0000_00AA, 32'h8765_4321, 1'b0, 5, 1, 3, 32'h8765_AA21);
    applyStimulus(1'b1, F3_H,  32'h12, 32'h0000_1234, 32'h8765_4321, 1'b0, 5, 1, 3, 32'h1234_AA21);
    applyStimulus(1'b1, F3_W,  32'h14, 32'hDEAD_BEEF, 32'h8765_4321, 1'b0, 3, 0, 1, 32'hDEAD_BEEF);
    applyStimulus(1'b0, F3_W,  32'h14, 32'h0, 32'hDEAD_BEEF, 1'b0, 4, 1, 0, 32'h0);
    applyStimulus(1'b0, F3_B,  32'h11, 32'h0, 32'hFFFF_FFAA, 1'b0, 4, 1, 0, 32'h0);
    applyStimulus(1'b0, F3_B,  32'h10, 32'h0, 32'h0000_0021, 1'b0, 4, 1, 0, 32'h0);

    // Illegal accesses: error pulse in cycle 2, no RAM traffic
    applyStimulus(1'b0, F3_W,   32'h12, 32'h0, 32'h0, 1'b1, 2, 0, 0, 32'h0);
    applyStimulus(1'b0, F3_H,   32'h11, 32'h0, 32'h0, 1'b1, 2, 0, 0, 32'h0);
    applyStimulus(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 2, 0, 0, 32'h0);
    applyStimulus(1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, 2, 0, 0, 32'h0);

    // Reset during the MERGE cycle of an SB must drop the pending write
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_B;
    req_addr   = 32'h10;
    req_wdata  = 32'h0000_00FF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    wr_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (ram_wrEn) wr_seen++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (ram_wrEn) wr_seen++;
    end
    checkOutput("midrst_no_write", wr_seen, 0);
    checkOutput("midrst_mem_kept", mem[4], 32'h1234_AA21);
    applyStimulus(1'b0, F3_W, 32'h10, 32'h0, 32'h1234_AA21, 1'b0, 4, 1, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
